mips150_lsu: RTL and testbench

Load/store unit that consumes the memory-control fields produced by the instruction decoder: Mask, MemWrite and MemtoReg. It turns each accepted memory op into a byte-lane data-memory transaction using a req/gnt/rvalid protocol. Load data is extracted and sign- or zero-extended, then returned for writeback. It sits between the execute stage and the data-memory port, and the pipeline is stalled via op_ready while the unit is busy.

---
 rtl/mips150_lsu_if.sv | 43 ++++
 rtl/mips150_lsu.sv | 178 +++++++++++++++++
 tb/tb_mips150_lsu.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips150_lsu_if.sv
// Execute-stage op handshake, data-memory port and load-return signals of the LSU.
interface mips150_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_mask;
  logic [1:0]        op_memwrite;
  logic              op_load;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [4:0]        op_rd;

  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              ld_valid;
  logic [31:0]       ld_data;
  logic [4:0]        ld_rd;
  logic              err_misalign;
  logic              err_timeout;

  // Environment side: issues ops and models the memory.
  modport master (
    output op_valid, op_mask, op_memwrite, op_load, op_addr, op_wdata, op_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  op_ready, mem_req, mem_addr, mem_we, mem_wdata,
    input  ld_valid, ld_data, ld_rd, err_misalign, err_timeout
  );

  // LSU side.
  modport slave (
    input  op_valid, op_mask, op_memwrite, op_load, op_addr, op_wdata, op_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output op_ready, mem_req, mem_addr, mem_we, mem_wdata,
    output ld_valid, ld_data, ld_rd, err_misalign, err_timeout
  );
endinterface

// File: rtl/mips150_lsu.sv
// Load/store unit: turns decoded memory ops into big-endian byte-lane req/gnt/rvalid
// transactions and returns extended load data for writeback.
module mips150_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  mips150_lsu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [7:0] TermCnt = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  logic [2:0]        mask_q;
  logic [4:0]        rd_q;
  logic              store_q;
  logic              ld_valid_q;
  logic [31:0]       ld_data_q;
  logic [4:0]        ld_rd_q;
  logic              err_mis_q;
  logic              err_to_q;

  logic        accept, is_store, is_load, bad, start, timeout;
  logic [3:0]  enc_we;
  logic [31:0] enc_wdata;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] mask);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'b00:   b = w[31:24];
      2'b01:   b = w[23:16];
      2'b10:   b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    unique case (mask)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b011:  return {24'd0, b};
      3'b100:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Decode and legality of the offered op.
  always_comb begin
    accept    = bus.op_valid && bus.op_ready;
    is_store  = (bus.op_memwrite != 2'b00);
    is_load   = !is_store && bus.op_load;
    bad       = 1'b0;
    enc_we    = 4'b0000;
    enc_wdata = 32'd0;
    if (is_store) begin
      unique case (bus.op_memwrite)
        2'b01: begin
          enc_we    = 4'b1000 >> bus.op_addr[1:0];
          enc_wdata = {4{bus.op_wdata[7:0]}};
        end
        2'b10: begin
          bad       = bus.op_addr[0];
          enc_we    = bus.op_addr[1] ? 4'b0011 : 4'b1100;
          enc_wdata = {2{bus.op_wdata[15:0]}};
        end
        default: begin
          bad       = (bus.op_addr[1:0] != 2'b00);
          enc_we    = 4'b1111;
          enc_wdata = bus.op_wdata;
        end
      endcase
    end else if (is_load) begin
      unique case (bus.op_mask)
        3'b000, 3'b011: bad = 1'b0;
        3'b001, 3'b100: bad = bus.op_addr[0];
        3'b010:         bad = (bus.op_addr[1:0] != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
    start = accept && (is_store || is_load) && !bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The awaited gnt/rvalid wins over the terminal count.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReq;
      end
      StReq: begin
        if (bus.mem_gnt) begin
          state_d = store_q ? StIdle : StResp;
        end else if (cnt_q == TermCnt) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      StResp: begin
        if (bus.mem_rvalid) begin
          state_d = StIdle;
        end else if (cnt_q == TermCnt) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q || state_q == StIdle) ? 8'd0 : cnt_q + 8'd1;
  end

  always_comb begin
    bus.op_ready     = rst_n && (state_q == StIdle);
    bus.mem_req      = (state_q == StReq);
    bus.mem_addr     = (state_q == StReq) ? addr_q : '0;
    bus.mem_we       = (state_q == StReq) ? we_q : 4'b0000;
    bus.mem_wdata    = (state_q == StReq) ? wdata_q : 32'd0;
    bus.ld_valid     = ld_valid_q;
    bus.ld_data      = ld_data_q;
    bus.ld_rd        = ld_rd_q;
    bus.err_misalign = err_mis_q;
    bus.err_timeout  = err_to_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      we_q       <= 4'b0000;
      wdata_q    <= 32'd0;
      off_q      <= 2'b00;
      mask_q     <= 3'b000;
      rd_q       <= 5'd0;
      store_q    <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'd0;
      ld_rd_q    <= 5'd0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ld_valid_q <= 1'b0;
      err_mis_q  <= accept && (is_store || is_load) && bad;
      err_to_q   <= timeout;
      if (start) begin
        addr_q  <= bus.op_addr[ADDR_W-1:2];
        we_q    <= enc_we;
        wdata_q <= enc_wdata;
        off_q   <= bus.op_addr[1:0];
        mask_q  <= bus.op_mask;
        rd_q    <= bus.op_rd;
        store_q <= is_store;
      end
      if (state_q == StResp && bus.mem_rvalid) begin
        ld_valid_q <= 1'b1;
        ld_data_q  <= extract(bus.mem_rdata, off_q, mask_q);
        ld_rd_q    <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mips150_lsu.sv
// Directed self-checking bench for mips150_lsu, built with TIMEOUT = 8.
module tb_mips150_lsu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips150_lsu_if #(.ADDR_W(32)) b ();

  mips150_lsu #(
    .ADDR_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic [2:0] mask, input logic [1:0] mw, input logic ld,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    b.op_valid    = 1'b1;
    b.op_mask     = mask;
    b.op_memwrite = mw;
    b.op_load     = ld;
    b.op_addr     = addr;
    b.op_wdata    = wd;
    b.op_rd       = rd;
    @(negedge clk);
    b.op_valid    = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({b.op_ready, b.mem_req, b.mem_addr, b.mem_we, b.mem_wdata, b.ld_valid, b.ld_data,
         b.ld_rd, b.err_misalign, b.err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b req=%b addr=%h we=%b wd=%h ldv=%b ldd=%h rd=%0d em=%b et=%b, required all 0",
               b.op_ready, b.mem_req, b.mem_addr, b.mem_we, b.mem_wdata, b.ld_valid,
               b.ld_data, b.ld_rd, b.err_misalign, b.err_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (b.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", b.op_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [2:0]  m [5] = '{3'b000, 3'b011, 3'b100, 3'b001, 3'b010};
    logic [31:0] a [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1004};
    logic [31:0] r [5] = '{32'h11223380, 32'h11223380, 32'h11223380, 32'h80001234,
                           32'hCAFEF00D};
    logic [31:0] e [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00003380, 32'hFFFF8000,
                           32'hCAFEF00D};
    for (int i = 0; i < 5; i++) begin
      issue(m[i], 2'b00, 1'b1, a[i], 32'h0, 5'(i + 3));
      checks++;
      if (b.mem_req !== 1'b1 || b.mem_we !== 4'b0000 || b.mem_addr !== a[i][31:2]) begin
        errors++;
        $display("FAIL load%0d_req: req=%b we=%b addr=%h required 1 0000 %h",
                 i, b.mem_req, b.mem_we, b.mem_addr, a[i][31:2]);
      end
      b.mem_gnt = 1'b1;
      @(negedge clk);
      b.mem_gnt    = 1'b0;
      b.mem_rvalid = 1'b1;
      b.mem_rdata  = r[i];
      checks++;
      if (b.mem_req !== 1'b0 || b.op_ready !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_resp: req=%b ready=%b required 0 0", i, b.mem_req, b.op_ready);
      end
      @(negedge clk);
      b.mem_rvalid = 1'b0;
      checks++;
      if (b.ld_valid !== 1'b1 || b.ld_data !== e[i] || b.ld_rd !== 5'(i + 3)) begin
        errors++;
        $display("FAIL load%0d_data: ldv=%b data=%h rd=%0d required 1 %h %0d",
                 i, b.ld_valid, b.ld_data, b.ld_rd, e[i], i + 3);
      end
      @(negedge clk);
      checks++;
      if (b.ld_valid !== 1'b0 || b.ld_data !== e[i] || b.op_ready !== 1'b1) begin
        errors++;
        $display("FAIL load%0d_after: ldv=%b data=%h ready=%b required 0 %h 1",
                 i, b.ld_valid, b.ld_data, b.op_ready, e[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [1:0]  w [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] a [3] = '{32'h2002, 32'h2001, 32'h2004};
    logic [31:0] d [3] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
    logic [3:0]  ew [3] = '{4'b0011, 4'b0100, 4'b1111};
    logic [31:0] ed [3] = '{32'hBEEFBEEF, 32'hEFEFEFEF, 32'h12345678};
    logic [29:0] ea [3] = '{30'h800, 30'h800, 30'h801};
    for (int i = 0; i < 3; i++) begin
      // op_load also high: the store must take priority.
      issue(3'b010, w[i], 1'b1, a[i], d[i], 5'd9);
      checks++;
      if (b.mem_req !== 1'b1 || b.mem_addr !== ea[i] || b.mem_we !== ew[i] ||
          b.mem_wdata !== ed[i]) begin
        errors++;
        $display("FAIL store%0d_req: req=%b addr=%h we=%b wd=%h required 1 %h %b %h",
                 i, b.mem_req, b.mem_addr, b.mem_we, b.mem_wdata, ea[i], ew[i], ed[i]);
      end
      b.mem_gnt = 1'b1;
      @(negedge clk);
      b.mem_gnt = 1'b0;
      checks++;
      if (b.mem_req !== 1'b0 || b.op_ready !== 1'b1 || b.mem_we !== 4'b0000 ||
          b.mem_wdata !== 32'h0 || b.ld_valid !== 1'b0) begin
        errors++;
        $display("FAIL store%0d_done: req=%b ready=%b we=%b wd=%h ldv=%b required 0 1 0000 0 0",
                 i, b.mem_req, b.op_ready, b.mem_we, b.mem_wdata, b.ld_valid);
      end
    end
  endtask

  task automatic test_stall();
    int req_cycles = 0;
    int pulses = 0;
    issue(3'b010, 2'b00, 1'b1, 32'h4, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      if (b.mem_req === 1'b1) req_cycles++;
      checks++;
      if (b.mem_addr !== 30'h1 || b.op_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_req%0d: addr=%h ready=%b required 1 0", i, b.mem_addr, b.op_ready);
      end
      if (i == 3) b.mem_gnt = 1'b1;
      @(negedge clk);
    end
    b.mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (b.mem_req === 1'b1) req_cycles++;
      checks++;
      if (b.op_ready !== 1'b0 || b.ld_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_resp%0d: ready=%b ldv=%b required 0 0", i, b.op_ready, b.ld_valid);
      end
      if (i == 1) begin
        b.mem_rvalid = 1'b1;
        b.mem_rdata  = 32'h0BADF00D;
      end
      @(negedge clk);
    end
    b.mem_rvalid = 1'b0;
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL stall_req_cycles: got %0d required 4", req_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      if (b.ld_valid === 1'b1) pulses++;
      if (i == 0) begin
        checks++;
        if (b.ld_valid !== 1'b1 || b.ld_data !== 32'h0BADF00D || b.ld_rd !== 5'd7) begin
          errors++;
          $display("FAIL stall_data: ldv=%b data=%h rd=%0d required 1 0badf00d 7",
                   b.ld_valid, b.ld_data, b.ld_rd);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1 || b.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_pulses: pulses=%0d ready=%b required 1 1", pulses, b.op_ready);
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  m [3] = '{3'b001, 3'b010, 3'b110};
    logic [1:0]  w [3] = '{2'b00, 2'b11, 2'b00};
    logic [31:0] a [3] = '{32'h1001, 32'h2, 32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(m[i], w[i], 1'b1, a[i], 32'h55, 5'd1);
      checks++;
      if (b.err_misalign !== 1'b1 || b.mem_req !== 1'b0 || b.op_ready !== 1'b1) begin
        errors++;
        $display("FAIL misalign%0d: err=%b req=%b ready=%b required 1 0 1",
                 i, b.err_misalign, b.mem_req, b.op_ready);
      end
    end
    // No-op, issued back to back.
    issue(3'b000, 2'b00, 1'b0, 32'h1, 32'h0, 5'd0);
    checks++;
    if (b.err_misalign !== 1'b0 || b.mem_req !== 1'b0 || b.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL noop: err=%b req=%b ready=%b required 0 0 1",
               b.err_misalign, b.mem_req, b.op_ready);
    end
    issue(3'b000, 2'b01, 1'b0, 32'h3, 32'hA5, 5'd0);
    checks++;
    if (b.mem_req !== 1'b1 || b.mem_we !== 4'b0001 || b.mem_wdata !== 32'hA5A5A5A5 ||
        b.err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_recover: req=%b we=%b wd=%h err=%b required 1 0001 a5a5a5a5 0",
               b.mem_req, b.mem_we, b.mem_wdata, b.err_misalign);
    end
    b.mem_gnt = 1'b1;
    @(negedge clk);
    b.mem_gnt = 1'b0;
  endtask

  task automatic test_timeout();
    // Load granted, rvalid never arrives.
    issue(3'b010, 2'b00, 1'b1, 32'h8, 32'h0, 5'd4);
    b.mem_gnt = 1'b1;
    @(negedge clk);
    b.mem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b.op_ready !== 1'b0 || b.err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_resp_wait%0d: ready=%b et=%b required 0 0", i, b.op_ready, b.err_timeout);
      end
      @(negedge clk);
    end
    checks++;
    if (b.err_timeout !== 1'b1 || b.op_ready !== 1'b1 || b.ld_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_resp_abort: et=%b ready=%b ldv=%b required 1 1 0",
               b.err_timeout, b.op_ready, b.ld_valid);
    end
    b.mem_rvalid = 1'b1;
    b.mem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    b.mem_rvalid = 1'b0;
    checks++;
    if (b.ld_valid !== 1'b0 || b.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_late_rvalid: ldv=%b et=%b required 0 0", b.ld_valid, b.err_timeout);
    end
    // Gnt never arrives: 8 REQ cycles then abort.
    issue(3'b000, 2'b00, 1'b1, 32'h10, 32'h0, 5'd2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b.mem_req !== 1'b1) begin
        errors++;
        $display("FAIL to_req_wait%0d: req=%b required 1", i, b.mem_req);
      end
      @(negedge clk);
    end
    checks++;
    if (b.err_timeout !== 1'b1 || b.mem_req !== 1'b0 || b.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_req_abort: et=%b req=%b ready=%b required 1 0 1",
               b.err_timeout, b.mem_req, b.op_ready);
    end
    // Gnt on the terminal-count cycle wins.
    issue(3'b000, 2'b11, 1'b0, 32'h14, 32'h1, 5'd0);
    repeat (7) @(negedge clk);
    b.mem_gnt = 1'b1;
    @(negedge clk);
    b.mem_gnt = 1'b0;
    checks++;
    if (b.err_timeout !== 1'b0 || b.op_ready !== 1'b1 || b.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_gnt_wins: et=%b ready=%b req=%b required 0 1 0",
               b.err_timeout, b.op_ready, b.mem_req);
    end
    @(negedge clk);
    checks++;
    if (b.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_gnt_wins_after: et=%b required 0", b.err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    issue(3'b010, 2'b00, 1'b1, 32'hC, 32'h0, 5'd6);
    b.mem_gnt = 1'b1;
    @(negedge clk);
    b.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b.op_ready, b.mem_req, b.mem_addr, b.mem_we, b.mem_wdata, b.ld_valid, b.ld_data,
         b.ld_rd, b.err_misalign, b.err_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ready=%b req=%b we=%b ldv=%b ldd=%h rd=%0d et=%b, required all 0",
               b.op_ready, b.mem_req, b.mem_we, b.ld_valid, b.ld_data, b.ld_rd, b.err_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    b.mem_rvalid = 1'b1;
    b.mem_rdata  = 32'h12345678;
    @(negedge clk);
    b.mem_rvalid = 1'b0;
    checks++;
    if (b.ld_valid !== 1'b0 || b.op_ready !== 1'b1 || b.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: ldv=%b ready=%b et=%b required 0 1 0",
               b.ld_valid, b.op_ready, b.err_timeout);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    b.op_valid    = 1'b0;
    b.op_mask     = 3'b000;
    b.op_memwrite = 2'b00;
    b.op_load     = 1'b0;
    b.op_addr     = 32'h0;
    b.op_wdata    = 32'h0;
    b.op_rd       = 5'd0;
    b.mem_gnt     = 1'b0;
    b.mem_rvalid  = 1'b0;
    b.mem_rdata   = 32'h0;
    #1;
    test_reset();
    test_loads();
    test_stores();
    test_stall();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
